// File: rtl/sat_accumulator.sv
// rtl/sat_accumulator.sv - saturating burst accumulator with valid/ready handshake
module sat_accumulator #(
  parameter int DATA_W    = 4,
  parameter int ACC_W     = 8,
  parameter int BURST_LEN = 4,
  parameter int SIGNED    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_sat,
  output logic              busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  // State is held as a raw 2-bit vector so the illegal code 2'b11 stays
  // representable and is explicitly steered back to IDLE.
  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic [ACC_W:0]   ext_data;
  logic [ACC_W:0]   acc_ext;
  logic [ACC_W:0]   sum;
  logic             add_sat;
  logic [ACC_W-1:0] add_res;
  logic [ACC_W-1:0] sat_val;

  // Handshake and status outputs decoded directly from the state register.
  always_comb begin
    in_ready  = (state_q != DONE) & ~clear;
    out_valid = (state_q == DONE);
    out_data  = acc_q;
    out_sat   = sat_q;
    busy      = (state_q != IDLE);
    accept    = in_valid & in_ready;
  end

  // Extend both addends one bit past the accumulator, add, then clamp on overflow.
  always_comb begin
    ext_data             = {(ACC_W + 1){(SIGNED != 0) & in_data[DATA_W-1]}};
    ext_data[DATA_W-1:0] = in_data;
    acc_ext              = {(SIGNED != 0) & acc_q[ACC_W-1], acc_q};
    sum                  = acc_ext + ext_data;
    if (SIGNED != 0) begin
      add_sat          = sum[ACC_W] ^ sum[ACC_W-1];
      sat_val          = {ACC_W{~sum[ACC_W]}};
      sat_val[ACC_W-1] = sum[ACC_W];
    end else begin
      add_sat = sum[ACC_W];
      sat_val = {ACC_W{1'b1}};
    end
    add_res = add_sat ? sat_val : sum[ACC_W-1:0];
  end

  // Next-state and datapath update; clear overrides any handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = ext_data[ACC_W-1:0];
            cnt_d   = CNT_W'(1);
            sat_d   = 1'b0;
            state_d = (BURST_LEN == 1) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = add_res;
            cnt_d = cnt_q + CNT_W'(1);
            sat_d = sat_q | add_sat;
            if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_sat_accumulator.sv
// tb/tb_sat_accumulator.sv - directed vector bench for sat_accumulator
module tb_sat_accumulator;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;

  // u0: unsigned 4->8, u1: unsigned 4->4, u2: signed 4->4 (all burst 4)
  logic       in_ready0, out_valid0, out_sat0, busy0;
  logic [7:0] out_data0;
  logic       in_ready1, out_valid1, out_sat1, busy1;
  logic [3:0] out_data1;
  logic       in_ready2, out_valid2, out_sat2, busy2;
  logic [3:0] out_data2;

  // u3: unsigned 4->8, burst 1, own handshake signals
  logic       in_valid3, out_ready3;
  logic [3:0] in_data3;
  logic       in_ready3, out_valid3, out_sat3, busy3;
  logic [7:0] out_data3;

  int n_cmp;
  int n_err;

  sat_accumulator #(.DATA_W(4), .ACC_W(8), .BURST_LEN(4), .SIGNED(0)) dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_sat(out_sat0), .busy(busy0));

  sat_accumulator #(.DATA_W(4), .ACC_W(4), .BURST_LEN(4), .SIGNED(0)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_sat(out_sat1), .busy(busy1));

  sat_accumulator #(.DATA_W(4), .ACC_W(4), .BURST_LEN(4), .SIGNED(1)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_sat(out_sat2), .busy(busy2));

  sat_accumulator #(.DATA_W(4), .ACC_W(8), .BURST_LEN(1), .SIGNED(0)) dut3 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_data(out_data3), .out_sat(out_sat3), .busy(busy3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Presents four operands back-to-back, one per cycle, starting at a negedge.
  // Leaves in_valid low at the negedge following the last accept.
  task automatic run_burst(input logic [15:0] ops);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("mid_burst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("mid_burst_busy", {31'd0, busy0}, 32'd1);
      end
      in_valid = 1'b1;
      in_data  = ops[4*i +: 4];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_release_busy0", {31'd0, busy0}, 32'd0);
    check("post_release_data0", {24'd0, out_data0}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] ops;
    logic [7:0]  e0;
    logic [3:0]  e1;
    logic        s1;
    logic [3:0]  e2;
    logic        s2;
  } vec_t;

  vec_t vecs[7];

  initial begin
    n_cmp = 0;
    n_err = 0;
    // ops packed as {op3, op2, op1, op0}
    vecs[0] = '{ops: {4'd9, 4'd7, 4'd5, 4'd3},     e0: 8'd24,  e1: 4'hF, s1: 1'b1, e2: 4'h0, s2: 1'b1};
    vecs[1] = '{ops: {4'd0, 4'd1, 4'd15, 4'd15},   e0: 8'd31,  e1: 4'hF, s1: 1'b1, e2: 4'hF, s2: 1'b0};
    vecs[2] = '{ops: {4'd0, 4'd1, 4'd8, 4'd8},     e0: 8'd17,  e1: 4'hF, s1: 1'b1, e2: 4'h9, s2: 1'b1};
    vecs[3] = '{ops: {4'd0, 4'd0, 4'd7, 4'd7},     e0: 8'd14,  e1: 4'hE, s1: 1'b0, e2: 4'h7, s2: 1'b1};
    vecs[4] = '{ops: {4'd0, 4'd0, 4'd0, 4'd0},     e0: 8'd0,   e1: 4'h0, s1: 1'b0, e2: 4'h0, s2: 1'b0};
    vecs[5] = '{ops: {4'd15, 4'd15, 4'd15, 4'd15}, e0: 8'd60,  e1: 4'hF, s1: 1'b1, e2: 4'hC, s2: 1'b0};
    vecs[6] = '{ops: {4'd8, 4'd4, 4'd2, 4'd1},     e0: 8'd15,  e1: 4'hF, s1: 1'b0, e2: 4'hF, s2: 1'b0};

    rst        = 1'b1;
    clear      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 4'd0;
    out_ready  = 1'b0;
    in_valid3  = 1'b0;
    in_data3   = 4'd0;
    out_ready3 = 1'b0;

    // Reset values
    #2;
    check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
    check("rst_out_data", {24'd0, out_data0}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven bursts across all three burst-4 configurations
    for (int v = 0; v < 7; v++) begin
      run_burst(vecs[v].ops);
      check("vec_out_valid0", {31'd0, out_valid0}, 32'd1);
      check("vec_in_ready0", {31'd0, in_ready0}, 32'd0);
      check("vec_data_u8", {24'd0, out_data0}, {24'd0, vecs[v].e0});
      check("vec_sat_u8", {31'd0, out_sat0}, 32'd0);
      check("vec_data_u4", {28'd0, out_data1}, {28'd0, vecs[v].e1});
      check("vec_sat_u4", {31'd0, out_sat1}, {31'd0, vecs[v].s1});
      check("vec_data_s4", {28'd0, out_data2}, {28'd0, vecs[v].e2});
      check("vec_sat_s4", {31'd0, out_sat2}, {31'd0, vecs[v].s2});
      release_result();
    end

    // Back-pressure: result held, operands refused while out_ready is low
    run_burst({4'd9, 4'd7, 4'd5, 4'd3});
    in_valid = 1'b1;
    in_data  = 4'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_out_valid", {31'd0, out_valid0}, 32'd1);
      check("hold_out_data", {24'd0, out_data0}, 32'd24);
      check("hold_out_sat_u4", {31'd0, out_sat1}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready0}, 32'd0);
    end
    in_valid = 1'b0;
    release_result();
    run_burst({4'd1, 4'd1, 4'd1, 4'd1});
    check("after_hold_data", {24'd0, out_data0}, 32'd4);
    check("after_hold_sat_u4", {31'd0, out_sat1}, 32'd0);
    release_result();

    // Clear after two operands; the operand in the clear cycle is dropped
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 4'd2;
    @(negedge clk);
    in_data  = 4'd3;
    @(negedge clk);
    clear    = 1'b1;
    in_data  = 4'd9;
    #1;
    check("clear_in_ready", {31'd0, in_ready0}, 32'd0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_busy", {31'd0, busy0}, 32'd0);
    check("clear_data", {24'd0, out_data0}, 32'd0);
    run_burst({4'd1, 4'd1, 4'd1, 4'd1});
    check("post_clear_data", {24'd0, out_data0}, 32'd4);
    check("post_clear_sat", {31'd0, out_sat0}, 32'd0);

    // Clear discards a pending result
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_done_out_valid", {31'd0, out_valid0}, 32'd0);
    check("clear_done_data", {24'd0, out_data0}, 32'd0);

    // Single-operand bursts go straight to DONE
    in_valid3 = 1'b1;
    in_data3  = 4'd9;
    @(negedge clk);
    in_valid3 = 1'b0;
    check("b1_out_valid", {31'd0, out_valid3}, 32'd1);
    check("b1_out_data", {24'd0, out_data3}, 32'd9);
    check("b1_in_ready", {31'd0, in_ready3}, 32'd0);
    out_ready3 = 1'b1;
    @(negedge clk);
    out_ready3 = 1'b0;
    check("b1_release_busy", {31'd0, busy3}, 32'd0);

    // Asynchronous reset between edges mid-burst
    in_valid = 1'b1;
    in_data  = 4'd6;
    @(negedge clk);
    in_data  = 4'd4;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_data", {24'd0, out_data0}, 32'd10);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, busy0}, 32'd0);
    check("async_rst_data", {24'd0, out_data0}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready0}, 32'd1);
    check("async_rst_out_valid", {31'd0, out_valid0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("after_rst_out_valid", {31'd0, out_valid0}, 32'd0);

    // Illegal state code returns to IDLE after one edge
    force dut0.state_q = 2'b11;
    #1;
    check("illegal_out_valid", {31'd0, out_valid0}, 32'd0);
    release dut0.state_q;
    @(negedge clk);
    check("illegal_recover_busy", {31'd0, busy0}, 32'd0);
    check("illegal_recover_in_ready", {31'd0, in_ready0}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
